// File: rtl/ram_4096_pkg.sv
// ram_4096_pkg: shared sizing and word/address types for the 4096-word RAM
// and its bus interface.
package ram_4096_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 12;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : ram_4096_pkg

// File: rtl/ram_4096_if.sv
// ram_if: write/read port bundle of the 4096-word RAM.
// Handshake: there is no ready/stall. A port acts on every rising edge its
// enable (write / read) is high. Read data appears on data_out one edge
// after read is sampled and holds until the next sampled read.
interface ram_if;
    import ram_4096_pkg::*;

    data_t data_in;
    addr_t wrt_address;
    logic  write;
    addr_t rd_address;
    logic  read;
    data_t data_out;

    // Requester side: drives addresses, enables and write data.
    modport master (
        output data_in, wrt_address, write, rd_address, read,
        input  data_out
    );

    // Storage side: owns data_out.
    modport slave (
        input  data_in, wrt_address, write, rd_address, read,
        output data_out
    );

endinterface : ram_if

// File: rtl/ram_4096_array.sv
// ram_4096_array: DEPTH x DATA_WIDTH storage with a synchronous write port and
// a synchronous, read-first read port. No reset on the array or its output
// register so the tools can map it onto block RAM.
module ram_4096_array
    import ram_4096_pkg::*;
(
    input  logic  clock,
    input  logic  we,
    input  addr_t wa,
    input  data_t wd,
    input  logic  re,
    input  addr_t ra,
    output data_t rq
);

    data_t mem [DEPTH];

    // Write port: store the word on an enabled edge.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Read port: the non-blocking update of mem means a same-address write in
    // this edge is not yet visible, giving read-first behaviour.
    always_ff @(posedge clock) begin
        if (re) begin
            rq <= mem[ra];
        end
    end

endmodule : ram_4096_array

// File: rtl/ram_4096.sv
// ram_4096: simple dual-port, single-clock 4096 x 64 RAM with a registered
// read port (latency 1) and an asynchronously cleared data_out.
// Build option RAM_4096_WRITE_FIRST_EN: when defined, a read and a write to
// the same address in the same edge return the new write data (bypass);
// when undefined the read returns the old contents (read-first).
module ram_4096
    import ram_4096_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    ram_if.slave   bus
);

    data_t arr_q;
    logic  out_valid;
    logic  arr_we;

    // A write in a cycle where reset is held is dropped.
    assign arr_we = bus.write & reset_n;

    ram_4096_array u_array (
        .clock (clock),
        .we    (arr_we),
        .wa    (bus.wrt_address),
        .wd    (bus.data_in),
        .re    (bus.read),
        .ra    (bus.rd_address),
        .rq    (arr_q)
    );

    // The array output register cannot be reset, so data_out is forced to
    // zero until the first read after reset has reloaded that register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
        end else if (bus.read) begin
            out_valid <= 1'b1;
        end
    end

`ifdef RAM_4096_WRITE_FIRST_EN
    logic  byp_sel;
    data_t byp_data;

    // Capture a same-address collision so the new word can replace the
    // read-first array output for the rest of this read's lifetime.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else if (bus.read) begin
            byp_sel <= bus.write && (bus.wrt_address == bus.rd_address);
            if (bus.write && (bus.wrt_address == bus.rd_address)) begin
                byp_data <= bus.data_in;
            end
        end
    end

    assign bus.data_out = !out_valid ? '0 :
                          (byp_sel ? byp_data : arr_q);
`else
    assign bus.data_out = out_valid ? arr_q : '0;
`endif

endmodule : ram_4096

// File: tb/tb_ram_4096.sv
// tb_ram_4096: directed scenarios plus a random operation mix for ram_4096,
// checked against an array-based reference model of the RAM.
module tb_ram_4096;
    import ram_4096_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    ram_if bus ();

    ram_4096 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- reference model ----------------
    data_t ref_mem   [DEPTH];
    bit    ref_known [DEPTH];
    data_t ref_out;
    bit    ref_out_known;

    // Expected data_out after each edge, consumed on the following negedge.
    logic [DATA_WIDTH-1:0] exp_q[$];
    bit                    known_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input data_t act, input data_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: data_out=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, let the edge happen, update the model.
    task automatic cycle(input bit w, input addr_t wa, input data_t d,
                         input bit r, input addr_t ra);
        bus.write       = w;
        bus.wrt_address = wa;
        bus.data_in     = d;
        bus.read        = r;
        bus.rd_address  = ra;
        @(posedge clock);
        if (!reset_n) begin
            ref_out       = '0;
            ref_out_known = 1'b1;
        end else begin
            if (r) begin
`ifdef RAM_4096_WRITE_FIRST_EN
                if (w && wa == ra) begin
                    ref_out       = d;
                    ref_out_known = 1'b1;
                end else begin
                    ref_out       = ref_mem[ra];
                    ref_out_known = ref_known[ra];
                end
`else
                ref_out       = ref_mem[ra];
                ref_out_known = ref_known[ra];
`endif
            end
            if (w) begin
                ref_mem[wa]   = d;
                ref_known[wa] = 1'b1;
            end
        end
        exp_q.push_back(ref_out);
        known_q.push_back(ref_out_known);
        #1;
    endtask

    // Drop reset between edges and confirm data_out clears without a clock.
    task automatic assert_reset();
        reset_n = 1'b0;
        #1;
        check("reset_async", bus.data_out, '0);
        exp_q.delete();
        known_q.delete();
        ref_out       = '0;
        ref_out_known = 1'b1;
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [DATA_WIDTH-1:0] e;
            bit                    k;
            e = exp_q.pop_front();
            k = known_q.pop_front();
            if (k) check("stream", bus.data_out, e);
        end
    end

    // ---------------- stimulus ----------------
    localparam data_t PAT_A = 64'hAAAA_0000_1111_2222;
    localparam data_t PAT_B = 64'hBBBB_3333_4444_5555;

    initial begin
        data_t coll_exp;
        bus.write       = 1'b0;
        bus.wrt_address = '0;
        bus.data_in     = '0;
        bus.read        = 1'b0;
        bus.rd_address  = '0;
        ref_out         = '0;
        ref_out_known   = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("reset_state", bus.data_out, '0);
        reset_n = 1'b1;

        // single write then read
        cycle(1, 12'h000, 64'hDEAD_BEEF_0123_4567, 0, 12'h000);
        cycle(0, 12'h000, '0, 1, 12'h000);
        check("single_rd", bus.data_out, 64'hDEAD_BEEF_0123_4567);

        // boundaries, read back in reverse order
        cycle(1, 12'h000, 64'h0123_4567_89AB_CDEF, 0, 12'h000);
        cycle(1, 12'h7FF, 64'hA5A5_5A5A_A5A5_5A5A, 0, 12'h000);
        cycle(1, 12'hFFF, 64'hFFFF_0000_FFFF_0000, 0, 12'h000);
        cycle(0, 12'h000, '0, 1, 12'hFFF);
        check("bound_fff", bus.data_out, 64'hFFFF_0000_FFFF_0000);
        cycle(0, 12'h000, '0, 1, 12'h7FF);
        check("bound_7ff", bus.data_out, 64'hA5A5_5A5A_A5A5_5A5A);
        cycle(0, 12'h000, '0, 1, 12'h000);
        check("bound_000", bus.data_out, 64'h0123_4567_89AB_CDEF);

        // simultaneous read/write to different addresses
        cycle(1, 12'h010, PAT_A, 0, 12'h000);
        cycle(1, 12'h020, PAT_B, 1, 12'h010);
        check("diff_addr_rd", bus.data_out, PAT_A);
        cycle(0, 12'h000, '0, 1, 12'h020);
        check("diff_addr_wr", bus.data_out, PAT_B);

        // same-address collision
        cycle(1, 12'h055, PAT_A, 0, 12'h000);
        cycle(1, 12'h055, PAT_B, 1, 12'h055);
`ifdef RAM_4096_WRITE_FIRST_EN
        coll_exp = PAT_B;
`else
        coll_exp = PAT_A;
`endif
        check("collision", bus.data_out, coll_exp);
        cycle(0, 12'h000, '0, 1, 12'h055);
        check("collision_next", bus.data_out, PAT_B);

        // hold: read idle while writes continue, including to the read address
        for (int i = 0; i < 5; i++) begin
            cycle(1, (i == 2) ? 12'h055 : addr_t'(12'h200 + i),
                  {$urandom, $urandom}, 0, 12'h055);
        end
        check("hold", bus.data_out, PAT_B);

        // reset mid-run: write during reset is dropped, contents survive
        cycle(1, 12'h012, 64'h1234_5678_9ABC_DEF0, 1, 12'h010);
        check("pre_reset_rd", bus.data_out, PAT_A);
        assert_reset();
        cycle(1, 12'h010, 64'hEEEE_EEEE_EEEE_EEEE, 1, 12'h010);
        check("in_reset", bus.data_out, '0);
        reset_n = 1'b1;
        #1;
        check("post_release_zero", bus.data_out, '0);
        cycle(0, 12'h000, '0, 1, 12'h010);
        check("post_reset_rd", bus.data_out, PAT_A);
        cycle(0, 12'h000, '0, 1, 12'h012);
        check("post_reset_rd2", bus.data_out, 64'h1234_5678_9ABC_DEF0);

        // fill a working window, then a random operation mix
        for (int i = 0; i < 64; i++) begin
            cycle(1, addr_t'(12'h100 + i), {$urandom, $urandom}, 0, 12'h000);
        end
        for (int n = 0; n < 1000; n++) begin
            bit    w, r;
            addr_t wa, ra;
            w  = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 2) != 0);
            wa = ($urandom_range(0, 3) == 0) ? addr_t'($urandom_range(0, DEPTH - 1))
                                             : addr_t'(12'h100 + $urandom_range(0, 63));
            ra = ($urandom_range(0, 7) == 0) ? wa
                                             : addr_t'(12'h100 + $urandom_range(0, 63));
            cycle(w, wa, {$urandom, $urandom}, r, ra);
        end
        cycle(0, 12'h000, '0, 0, 12'h000);

        repeat (2) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ram_4096
